// File: rtl/gol_pkg.sv
// gol_pkg
// Shared definitions for the Game of Life generation sequencer slice.
// Contents:
//   GOL_ADDR_W          - default on-chip memory address width
//   GOL_GEN_W           - default generation counter width
//   GOL_TIMEOUT_CYCLES  - default per-generation watchdog limit
//   seq_state_t         - sequencer state encoding
package gol_pkg;

  localparam int GOL_ADDR_W         = 12;
  localparam int GOL_GEN_W          = 16;
  localparam int GOL_TIMEOUT_CYCLES = 1048576;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } seq_state_t;

endpackage

// File: rtl/gol_seq_watchdog.sv
// gol_seq_watchdog
// Per-generation cycle counter with an expiry flag.
// Ports:
//   clock, reset  - system clock, async active-high reset
//   clear         - restart the count from zero (wins over count_en)
//   count_en      - advance the count this cycle
//   expired       - this cycle is the TIMEOUT_CYCLES-th counted cycle
module gol_seq_watchdog
  import gol_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = GOL_TIMEOUT_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int               CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The counter parks at LIMIT; expiry is flagged while counting there so the
  // state change lands exactly TIMEOUT_CYCLES edges after the clear.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = count_en && (cnt_q == LIMIT);

endmodule

// File: rtl/gol_generation_sequencer.sv
// gol_generation_sequencer
// Runs a multi-generation Game of Life job on GameOfLifeWrapper, one
// generation at a time, ping-ponging two board buffers.
// Ports:
//   clock, reset        - 50 MHz fabric clock, async active-high reset
//   cmd_start           - PIO level; rising edge launches a run
//   cmd_abort           - PIO level; forces IDLE while high
//   cfg_gen_count       - generations to compute (latched on start)
//   cfg_base_a/b        - board buffers A (initial board) and B
//   eng_enable          - wrapper io_enable
//   eng_start_addr      - wrapper io_starting_address
//   eng_result_addr     - wrapper io_result_address
//   eng_completed       - wrapper io_completed
//   sts_busy/done/error - run in progress / finished / watchdog expired
//   sts_gen_done        - generations completed in the current run
//   sts_final_addr      - buffer holding the latest completed board
module gol_generation_sequencer
  import gol_pkg::*;
#(
  parameter int ADDR_W         = GOL_ADDR_W,
  parameter int GEN_W          = GOL_GEN_W,
  parameter int TIMEOUT_CYCLES = GOL_TIMEOUT_CYCLES
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_start,
  input  logic              cmd_abort,
  input  logic [GEN_W-1:0]  cfg_gen_count,
  input  logic [ADDR_W-1:0] cfg_base_a,
  input  logic [ADDR_W-1:0] cfg_base_b,
  output logic              eng_enable,
  output logic [ADDR_W-1:0] eng_start_addr,
  output logic [ADDR_W-1:0] eng_result_addr,
  input  logic              eng_completed,
  output logic              sts_busy,
  output logic              sts_done,
  output logic              sts_error,
  output logic [GEN_W-1:0]  sts_gen_done,
  output logic [ADDR_W-1:0] sts_final_addr
);

  seq_state_t        state_q, state_d;
  logic              start_prev_q;
  logic [GEN_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic              enable_q, enable_d;
  logic [ADDR_W-1:0] start_addr_q, start_addr_d;
  logic [ADDR_W-1:0] result_addr_q, result_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [GEN_W-1:0]  gen_done_q, gen_done_d;
  logic [ADDR_W-1:0] final_addr_q, final_addr_d;

  logic start_edge;
  logic wd_clear;
  logic wd_count_en;
  logic wd_expired;

  assign start_edge  = cmd_start & ~start_prev_q;
  assign wd_count_en = (state_q == ST_RUN) || (state_q == ST_DRAIN);

  gol_seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (wd_clear),
    .count_en(wd_count_en),
    .expired (wd_expired)
  );

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    src_d         = src_q;
    dst_d         = dst_q;
    done_d        = done_q;
    error_d       = error_q;
    gen_done_d    = gen_done_q;
    final_addr_d  = final_addr_q;
    start_addr_d  = start_addr_q;
    result_addr_d = result_addr_q;

    if (cmd_abort) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
      error_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start_edge) begin
            count_d    = cfg_gen_count;
            src_d      = cfg_base_a;
            dst_d      = cfg_base_b;
            gen_done_d = '0;
            done_d     = 1'b0;
            error_d    = 1'b0;
            if (cfg_gen_count == '0) begin
              state_d      = ST_DONE;
              done_d       = 1'b1;
              final_addr_d = cfg_base_a;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        // Expiry is tested ahead of completion so a late completion still errors.
        ST_RUN: begin
          if (wd_expired) begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end else if (eng_completed) begin
            gen_done_d   = (gen_done_q == '1) ? gen_done_q : gen_done_q + GEN_W'(1);
            final_addr_d = dst_q;
            src_d        = dst_q;
            dst_d        = src_q;
            state_d      = ST_DRAIN;
          end
        end
        // Hold off the next generation until the wrapper drops io_completed.
        ST_DRAIN: begin
          if (wd_expired) begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end else if (!eng_completed) begin
            if (gen_done_q == count_q) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    enable_d = (state_d == ST_RUN);
    busy_d   = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    wd_clear = (state_d == ST_RUN) && (state_q != ST_RUN);

    // Addresses only move on RUN entry, i.e. while enable is still low.
    if (wd_clear) begin
      start_addr_d  = src_d;
      result_addr_d = dst_d;
    end
  end

  // start_prev_q resets high so a start level held through reset is not an edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      start_prev_q  <= 1'b1;
      count_q       <= '0;
      src_q         <= '0;
      dst_q         <= '0;
      enable_q      <= 1'b0;
      start_addr_q  <= '0;
      result_addr_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      gen_done_q    <= '0;
      final_addr_q  <= '0;
    end else begin
      state_q       <= state_d;
      start_prev_q  <= cmd_start;
      count_q       <= count_d;
      src_q         <= src_d;
      dst_q         <= dst_d;
      enable_q      <= enable_d;
      start_addr_q  <= start_addr_d;
      result_addr_q <= result_addr_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
      gen_done_q    <= gen_done_d;
      final_addr_q  <= final_addr_d;
    end
  end

  assign eng_enable      = enable_q;
  assign eng_start_addr  = start_addr_q;
  assign eng_result_addr = result_addr_q;
  assign sts_busy        = busy_q;
  assign sts_done        = done_q;
  assign sts_error       = error_q;
  assign sts_gen_done    = gen_done_q;
  assign sts_final_addr  = final_addr_q;

endmodule

// File: tb/tb_gol_generation_sequencer.sv
// tb_gol_generation_sequencer
// Scoreboard bench: stimulus pushes expected generation launches and
// end-of-run status into queues; a monitor pops them when the DUT shows an
// enable rise or a status change. A small wrapper model answers enable.
`timescale 1ns/1ps
module tb_gol_generation_sequencer;

  localparam int ADDR_W  = 12;
  localparam int GEN_W   = 16;
  localparam int TIMEOUT = 64;

  logic              clock = 1'b0;
  logic              reset;
  logic              cmd_start;
  logic              cmd_abort;
  logic [GEN_W-1:0]  cfg_gen_count;
  logic [ADDR_W-1:0] cfg_base_a;
  logic [ADDR_W-1:0] cfg_base_b;
  logic              eng_enable;
  logic [ADDR_W-1:0] eng_start_addr;
  logic [ADDR_W-1:0] eng_result_addr;
  logic              eng_completed;
  logic              sts_busy;
  logic              sts_done;
  logic              sts_error;
  logic [GEN_W-1:0]  sts_gen_done;
  logic [ADDR_W-1:0] sts_final_addr;

  typedef struct {
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [GEN_W-1:0]  gd;
    int                cyc;
  } gen_exp_t;

  typedef struct {
    logic              done;
    logic              err;
    logic [GEN_W-1:0]  gd;
    logic [ADDR_W-1:0] fin;
    int                cyc;
  } stat_exp_t;

  gen_exp_t  gen_q[$];
  stat_exp_t stat_q[$];

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  bit wrapper_on = 1'b1;

  gol_generation_sequencer #(
    .ADDR_W(ADDR_W),
    .GEN_W(GEN_W),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .cmd_start      (cmd_start),
    .cmd_abort      (cmd_abort),
    .cfg_gen_count  (cfg_gen_count),
    .cfg_base_a     (cfg_base_a),
    .cfg_base_b     (cfg_base_b),
    .eng_enable     (eng_enable),
    .eng_start_addr (eng_start_addr),
    .eng_result_addr(eng_result_addr),
    .eng_completed  (eng_completed),
    .sts_busy       (sts_busy),
    .sts_done       (sts_done),
    .sts_error      (sts_error),
    .sts_gen_done   (sts_gen_done),
    .sts_final_addr (sts_final_addr)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [GEN_W-1:0] count, input logic [ADDR_W-1:0] a,
                               input logic [ADDR_W-1:0] b, output int start_cyc);
    cfg_gen_count = count;
    cfg_base_a    = a;
    cfg_base_b    = b;
    cmd_start     = 1'b0;
    @(negedge clock);
    cmd_start = 1'b1;
    start_cyc = cyc;
  endtask

  task automatic pushGen(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                         input logic [GEN_W-1:0] g, input int c);
    gen_q.push_back('{src: s, dst: d, gd: g, cyc: c});
  endtask

  task automatic pushStat(input logic dn, input logic er, input logic [GEN_W-1:0] g,
                          input logic [ADDR_W-1:0] f, input int c);
    stat_q.push_back('{done: dn, err: er, gd: g, fin: f, cyc: c});
  endtask

  task automatic waitStatus(input int max_cycles);
    int i = 0;
    while (stat_q.size() != 0 && i < max_cycles) begin
      @(negedge clock);
      #1;
      i++;
    end
    if (stat_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL status_timeout: got %0d pending events, expected 0 after %0d cycles",
               stat_q.size(), max_cycles);
      stat_q.delete();
      gen_q.delete();
    end
  endtask

  // Wrapper model: completed rises 10 cycles into enable, falls 2 cycles after enable drops.
  initial begin
    int en_cnt;
    int dis_cnt;
    eng_completed = 1'b0;
    en_cnt  = 0;
    dis_cnt = 0;
    forever begin
      @(negedge clock);
      if (!wrapper_on) begin
        eng_completed = 1'b0;
        en_cnt  = 0;
        dis_cnt = 0;
      end else if (eng_enable === 1'b1) begin
        dis_cnt = 0;
        en_cnt++;
        if (en_cnt == 10) eng_completed = 1'b1;
      end else begin
        en_cnt = 0;
        if (eng_completed) begin
          dis_cnt++;
          if (dis_cnt == 2) begin
            eng_completed = 1'b0;
            dis_cnt = 0;
          end
        end
      end
    end
  end

  // Monitor: enable rises pop launch expectations; busy falling or done/error rising pop status.
  initial begin
    gen_exp_t  cur;
    stat_exp_t se;
    logic prev_en, prev_busy, prev_done, prev_err;
    cur       = '{src: '0, dst: '0, gd: '0, cyc: 0};
    prev_en   = 1'b0;
    prev_busy = 1'b0;
    prev_done = 1'b0;
    prev_err  = 1'b0;
    forever begin
      @(negedge clock);
      if (eng_enable === 1'b1 && prev_en !== 1'b1) begin
        if (gen_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_enable: got rise at cycle %0d, expected none", cyc);
        end else begin
          cur = gen_q.pop_front();
          checkOutput("gen_start_addr", 32'(eng_start_addr), 32'(cur.src));
          checkOutput("gen_result_addr", 32'(eng_result_addr), 32'(cur.dst));
          checkOutput("gen_done_at_rise", 32'(sts_gen_done), 32'(cur.gd));
          checkOutput("gen_busy_at_rise", 32'(sts_busy), 32'd1);
          if (cur.cyc >= 0) checkOutput("gen_rise_cycle", cyc, cur.cyc);
        end
      end else if (eng_enable === 1'b1) begin
        checkOutput("stable_start_addr", 32'(eng_start_addr), 32'(cur.src));
        checkOutput("stable_result_addr", 32'(eng_result_addr), 32'(cur.dst));
      end
      if ((prev_busy && !sts_busy) || (sts_done && !prev_done) || (sts_error && !prev_err)) begin
        if (stat_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_status: got busy=%0b done=%0b error=%0b at cycle %0d, expected no event",
                   sts_busy, sts_done, sts_error, cyc);
        end else begin
          se = stat_q.pop_front();
          checkOutput("stat_done", 32'(sts_done), 32'(se.done));
          checkOutput("stat_error", 32'(sts_error), 32'(se.err));
          checkOutput("stat_busy", 32'(sts_busy), 32'd0);
          checkOutput("stat_enable", 32'(eng_enable), 32'd0);
          checkOutput("stat_gen_done", 32'(sts_gen_done), 32'(se.gd));
          checkOutput("stat_final_addr", 32'(sts_final_addr), 32'(se.fin));
          if (se.cyc >= 0) checkOutput("stat_cycle", cyc, se.cyc);
        end
      end
      prev_en   = eng_enable;
      prev_busy = sts_busy;
      prev_done = sts_done;
      prev_err  = sts_error;
    end
  end

  initial begin
    int c;
    reset         = 1'b1;
    cmd_start     = 1'b0;
    cmd_abort     = 1'b0;
    cfg_gen_count = '0;
    cfg_base_a    = '0;
    cfg_base_b    = '0;
    #2;
    checkOutput("reset_enable", 32'(eng_enable), 32'd0);
    checkOutput("reset_busy", 32'(sts_busy), 32'd0);
    checkOutput("reset_done", 32'(sts_done), 32'd0);
    checkOutput("reset_final_addr", 32'(sts_final_addr), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;

    // Three generations A=0x000, B=0x800.
    applyStimulus(16'd3, 12'h000, 12'h800, c);
    pushGen(12'h000, 12'h800, 16'd0, c + 1);
    pushGen(12'h800, 12'h000, 16'd1, c + 13);
    pushGen(12'h000, 12'h800, 16'd2, c + 25);
    pushStat(1'b1, 1'b0, 16'd3, 12'h800, c + 37);
    waitStatus(200);

    // Config changed mid-run must not affect the latched run.
    applyStimulus(16'd2, 12'h100, 12'h300, c);
    pushGen(12'h100, 12'h300, 16'd0, c + 1);
    pushGen(12'h300, 12'h100, 16'd1, c + 13);
    pushStat(1'b1, 1'b0, 16'd2, 12'h100, c + 25);
    @(negedge clock);
    cfg_gen_count = 16'd7;
    cfg_base_a    = 12'h222;
    cfg_base_b    = 12'h555;
    waitStatus(200);

    // Abort during generation 2 of 5, then restart from A.
    applyStimulus(16'd5, 12'h000, 12'h800, c);
    pushGen(12'h000, 12'h800, 16'd0, c + 1);
    pushGen(12'h800, 12'h000, 16'd1, c + 13);
    pushStat(1'b0, 1'b0, 16'd1, 12'h800, c + 16);
    repeat (15) @(negedge clock);
    cmd_abort = 1'b1;
    waitStatus(50);
    cmd_abort = 1'b0;
    applyStimulus(16'd2, 12'h000, 12'h800, c);
    pushGen(12'h000, 12'h800, 16'd0, c + 1);
    pushGen(12'h800, 12'h000, 16'd1, c + 13);
    pushStat(1'b1, 1'b0, 16'd2, 12'h000, c + 25);
    waitStatus(200);

    // Watchdog with completion stuck low.
    wrapper_on = 1'b0;
    applyStimulus(16'd3, 12'h040, 12'h080, c);
    pushGen(12'h040, 12'h080, 16'd0, c + 1);
    pushStat(1'b0, 1'b1, 16'd0, 12'h000, c + 1 + TIMEOUT);
    waitStatus(200);
    repeat (3) @(negedge clock);
    #1;
    checkOutput("error_held", 32'(sts_error), 32'd1);

    // Start from ERROR, then async reset mid-RUN off the clock edge.
    wrapper_on = 1'b1;
    applyStimulus(16'd3, 12'h000, 12'h800, c);
    pushGen(12'h000, 12'h800, 16'd0, c + 1);
    repeat (5) @(negedge clock);
    pushStat(1'b0, 1'b0, 16'd0, 12'h000, -1);
    #3 reset = 1'b1;
    #1;
    checkOutput("async_enable", 32'(eng_enable), 32'd0);
    checkOutput("async_start_addr", 32'(eng_start_addr), 32'd0);
    checkOutput("async_result_addr", 32'(eng_result_addr), 32'd0);
    checkOutput("async_busy", 32'(sts_busy), 32'd0);
    checkOutput("async_done", 32'(sts_done), 32'd0);
    checkOutput("async_error", 32'(sts_error), 32'd0);
    checkOutput("async_gen_done", 32'(sts_gen_done), 32'd0);
    checkOutput("async_final_addr", 32'(sts_final_addr), 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    #1;
    checkOutput("held_start_busy", 32'(sts_busy), 32'd0);
    checkOutput("held_start_enable", 32'(eng_enable), 32'd0);
    waitStatus(10);

    // Zero-count runs.
    applyStimulus(16'd0, 12'h000, 12'h800, c);
    pushStat(1'b1, 1'b0, 16'd0, 12'h000, c + 1);
    waitStatus(20);
    cmd_abort = 1'b1;
    @(negedge clock);
    #1;
    cmd_abort = 1'b0;
    checkOutput("abort_clears_done", 32'(sts_done), 32'd0);
    applyStimulus(16'd0, 12'h3a0, 12'h800, c);
    pushStat(1'b1, 1'b0, 16'd0, 12'h3a0, c + 1);
    waitStatus(20);

    repeat (5) @(negedge clock);
    #1;
    checkOutput("gen_queue_empty", 32'(gen_q.size()), 32'd0);
    checkOutput("stat_queue_empty", 32'(stat_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/gol_generation_sequencer.md
# gol_generation_sequencer

Control stage directly upstream of `GameOfLifeWrapper`. It takes a multi-generation run request from HPS PIO registers and drives the wrapper's `io_enable`, `io_starting_address` and `io_result_address` one generation at a time. Between generations it ping-pongs two on-chip-memory board buffers. It reports progress, completion, the buffer holding the final board, and a watchdog error back to the HPS.

## Interface
Parameters:
- `ADDR_W`, 12: on-chip memory address width; matches the wrapper address port.
- `GEN_W`, 16: width of the generation count and of the progress counter.
- `TIMEOUT_CYCLES`, 1048576: maximum cycles allowed per generation.

Ports:
- `clock`, in, 1: system clock, the fabric 50 MHz clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `cmd_start`, in, 1: PIO level. A rising edge launches a run.
- `cmd_abort`, in, 1: PIO level. While high, the sequencer is forced to IDLE.
- `cfg_gen_count`, in, GEN_W: number of generations to compute.
- `cfg_base_a`, in, ADDR_W: board buffer A, which holds the initial board.
- `cfg_base_b`, in, ADDR_W: board buffer B.
- `eng_enable`, out, 1: drives the wrapper `io_enable`.
- `eng_start_addr`, out, ADDR_W: drives the wrapper `io_starting_address`.
- `eng_result_addr`, out, ADDR_W: drives the wrapper `io_result_address`.
- `eng_completed`, in, 1: from the wrapper `io_completed`.
- `sts_busy`, out, 1: a run is in progress.
- `sts_done`, out, 1: the run finished.
- `sts_error`, out, 1: the watchdog expired.
- `sts_gen_done`, out, GEN_W: generations completed in the current run.
- `sts_final_addr`, out, ADDR_W: buffer holding the latest completed board.

## Operation
- All inputs are in the `clock` domain. No synchronisers are used. `cmd_start` is edge-detected through one register.
- **Start latching.** On a start edge, `cfg_*` are latched. Later changes to `cfg_*` are ignored until the next start edge.
- **States:** IDLE, RUN, DRAIN, DONE, ERROR.
- **IDLE or DONE or ERROR + start edge:**
  - Clear `sts_gen_done`, `sts_done` and `sts_error`.
  - Set src = A and dst = B.
  - If the latched count is 0: go to DONE with `sts_final_addr` = A.
  - Otherwise: go to RUN.
- **RUN:**
  - `eng_enable`=1, `eng_start_addr`=src, `eng_result_addr`=dst.
  - When `eng_completed`=1: increment `sts_gen_done`, set `sts_final_addr`=dst, swap src and dst, go to DRAIN.
- **DRAIN:**
  - `eng_enable`=0. Wait for `eng_completed`=0.
  - Then, if `sts_gen_done` equals the count: go to DONE. Otherwise: go to RUN.
- **DONE:** `sts_done`=1, held until a start edge or an abort.
- **Watchdog:**
  - The counter clears on every entry to RUN.
  - It counts during RUN and DRAIN.
  - Reaching `TIMEOUT_CYCLES` means: go to ERROR, `eng_enable`=0, `sts_error`=1.
  - ERROR is left only by a start edge or an abort.
- **Abort:**
  - `cmd_abort`=1 in any state means: go to IDLE and clear `sts_done`/`sts_error`.
  - `sts_gen_done` and `sts_final_addr` keep their values.
  - Abort has priority over a start edge in the same cycle.
- **Retrigger:** A start edge during RUN or DRAIN is ignored.
- `sts_busy`=1 exactly in RUN and DRAIN.
- `sts_gen_done` saturates at all-ones. It cannot wrap, because the count is bounded by the same width.

## Timing
- **Registered outputs.** All outputs are registered and change on the `clock` edge after the state decision.
- **Reset values.**
  - The asynchronous `reset` forces IDLE immediately.
  - All outputs go to 0. This includes `eng_enable`=0 and both address outputs = 0.
  - Reset mid-run drops `eng_enable` without waiting for the wrapper.
- **Latencies.**
  - Start edge sampled in cycle N: `eng_enable`=1 and the addresses are valid in N+1.
  - `eng_completed` high in cycle M: `eng_enable`=0 in M+1.
  - Next generation: `eng_enable` rises in the cycle after `eng_completed` is sampled low.
- **Address stability.** Addresses change only while `eng_enable`=0. They are stable for the whole of RUN.
- **Zero-count run.** `sts_done`=1 at N+1 with no `eng_enable` pulse.
- **Timeout boundary.** Expiry is checked before completion. Completion arriving in the expiry cycle still results in ERROR.

## Structure
- Shared package `gol_pkg` holds:
  - the state enum `seq_state_t`;
  - `ADDR_W` and `GEN_W` defaults;
  - the default timeout constant.
- Sub-module `gol_seq_watchdog`: a loadable/clearable counter with an `expired` flag, parameterised by `TIMEOUT_CYCLES`.
- The top-level `gol` instantiates the sequencer between the soc_system PIOs and `GameOfLifeWrapper`.

## Test plan
- **Three-generation run.** Count=3, A=0x000, B=0x800; model wrapper asserts completed 10 cycles after enable and clears it 2 cycles after enable falls.
  - Enable pulses carry (0x000→0x800), (0x800→0x000), (0x000→0x800).
  - Ends with `sts_done`=1, `sts_gen_done`=3, `sts_final_addr`=0x800.
- **Zero count.** Count=0, start edge → `sts_done`=1 one cycle later, `sts_final_addr`=0x000, `eng_enable` never high.
- **Watchdog.** `TIMEOUT_CYCLES`=64, completed stuck low.
  - `sts_error`=1 and `eng_enable`=0 exactly 64 cycles after entering RUN; `sts_busy`=0.
- **Abort.** Abort during generation 2 of 5.
  - Next cycle: IDLE, `eng_enable`=0, `sts_gen_done`=1, `sts_done`=0.
  - A new start edge restarts from A with the count cleared.
- **Reset and start level.** Async `reset` pulse mid-RUN, off a clock edge, gives all outputs 0 immediately. A `cmd_start` held high after reset does not launch a run without a fresh rising edge.
- **Config latch.** Change `cfg_gen_count`/`cfg_base_b` during the run; the run completes using the latched values.
